// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Shares one 1-cycle-latency SRAM between fetch and data ports; data has     |
// | priority with a bounded streak, read data is routed back to its owner.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int AWIDTH       = 12,
  parameter int DWIDTH       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                I_REQ,
  input  logic [AWIDTH-1:0]   I_ADDR,
  output logic                I_GNT,
  output logic                I_RVALID,
  output logic [DWIDTH-1:0]   I_RDATA,
  input  logic                D_REQ,
  input  logic                D_WEN,
  input  logic [AWIDTH-1:0]   D_ADDR,
  input  logic [DWIDTH/8-1:0] D_BE,
  input  logic [DWIDTH-1:0]   D_WDATA,
  output logic                D_GNT,
  output logic                D_RVALID,
  output logic [DWIDTH-1:0]   D_RDATA,
  output logic                M_CSN,
  output logic                M_WEN,
  output logic [AWIDTH-1:0]   M_ADDR,
  output logic [DWIDTH/8-1:0] M_BE,
  output logic [DWIDTH-1:0]   M_DI,
  input  logic [DWIDTH-1:0]   M_DOUT
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] c_MAX_STREAK = MAX_D_STREAK[3:0];

  owner_t     r_owner;
  owner_t     w_owner_nxt;
  logic [3:0] r_streak;
  logic [3:0] w_streak_nxt;
  logic       w_grant_i;
  logic       w_grant_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_owner  <= OWN_NONE;
      r_streak <= 4'd0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Fetch wins a contested cycle only once data has used up its streak allowance.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!RST) begin
      if (I_REQ && (!D_REQ || (r_streak == c_MAX_STREAK))) begin
        w_grant_i = 1'b1;
      end else if (D_REQ) begin
        w_grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    M_CSN  = 1'b1;
    M_WEN  = 1'b1;
    M_ADDR = '0;
    M_BE   = '0;
    M_DI   = '0;
    if (w_grant_i) begin
      M_CSN  = 1'b0;
      M_ADDR = I_ADDR;
    end else if (w_grant_d) begin
      M_CSN  = 1'b0;
      M_WEN  = D_WEN;
      M_ADDR = D_ADDR;
      M_BE   = D_BE;
      M_DI   = D_WDATA;
    end
  end

  always_comb begin
    w_owner_nxt  = OWN_NONE;
    w_streak_nxt = r_streak;
    if (w_grant_i) begin
      w_owner_nxt = OWN_I;
    end else if (w_grant_d && D_WEN) begin
      w_owner_nxt = OWN_D;
    end
    if (w_grant_i || !I_REQ) begin
      w_streak_nxt = 4'd0;
    end else if (w_grant_d && (r_streak < c_MAX_STREAK)) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  assign I_GNT    = w_grant_i;
  assign D_GNT    = w_grant_d;
  assign I_RVALID = (r_owner == OWN_I);
  assign D_RVALID = (r_owner == OWN_D);
  assign I_RDATA  = I_RVALID ? M_DOUT : '0;
  assign D_RDATA  = D_RVALID ? M_DOUT : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Directed bench with SRAM model, reference arbiter and read scoreboard.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_REQ;
  logic [11:0] I_ADDR;
  logic        I_GNT;
  logic        I_RVALID;
  logic [31:0] I_RDATA;
  logic        D_REQ;
  logic        D_WEN;
  logic [11:0] D_ADDR;
  logic [3:0]  D_BE;
  logic [31:0] D_WDATA;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic        M_CSN;
  logic        M_WEN;
  logic [11:0] M_ADDR;
  logic [3:0]  M_BE;
  logic [31:0] M_DI;
  logic [31:0] M_DOUT;

  mem_port_arbiter #(.AWIDTH(12), .DWIDTH(32), .MAX_D_STREAK(4)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WEN(D_WEN), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_DI(M_DI),
    .M_DOUT(M_DOUT)
  );

  always #5 CLK = ~CLK;

  logic [31:0] sram    [0:4095];
  logic [31:0] ref_mem [0:4095];

  // SRAM model driven only by the DUT's M_* pins.
  always @(posedge CLK) begin
    if (!M_CSN) begin
      if (!M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) sram[M_ADDR][8*b +: 8] = M_DI[8*b +: 8];
      end else begin
        M_DOUT <= sram[M_ADDR];
      end
    end
  end

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [3:0]  m_streak = 4'd0;
  logic [1:0]  last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: compare returns and grants at the negedge, advance the model, then move past the edge.
  task automatic step();
    exp_t e;
    logic gi;
    logic gd;
    @(negedge CLK);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("i_rvalid", {31'd0, I_RVALID}, {31'd0, !e.is_d});
      chk("d_rvalid", {31'd0, D_RVALID}, {31'd0, e.is_d});
      chk("i_rdata", I_RDATA, e.is_d ? 32'd0 : e.data);
      chk("d_rdata", D_RDATA, e.is_d ? e.data : 32'd0);
    end else begin
      chk("rvalid_idle", {30'd0, I_RVALID, D_RVALID}, 32'd0);
    end
    gi = I_REQ && (!D_REQ || (m_streak == 4'd4));
    gd = D_REQ && !gi;
    chk("grants", {30'd0, D_GNT, I_GNT}, {30'd0, gd, gi});
    chk("m_csn", {31'd0, M_CSN}, {31'd0, !(gi || gd)});
    last_gnt = {D_GNT, I_GNT};
    if (gi) begin
      chk("m_addr_i", {20'd0, M_ADDR}, {20'd0, I_ADDR});
      chk("m_wen_be_i", {27'd0, M_WEN, M_BE}, 32'h10);
      q.push_back('{is_d: 1'b0, data: ref_mem[I_ADDR]});
    end else if (gd) begin
      chk("m_addr_d", {20'd0, M_ADDR}, {20'd0, D_ADDR});
      chk("m_wen_d", {31'd0, M_WEN}, {31'd0, D_WEN});
      if (D_WEN) begin
        q.push_back('{is_d: 1'b1, data: ref_mem[D_ADDR]});
      end else begin
        for (int b = 0; b < 4; b++)
          if (D_BE[b]) ref_mem[D_ADDR][8*b +: 8] = D_WDATA[8*b +: 8];
      end
    end
    if (gi || !I_REQ) m_streak = 4'd0;
    else if (gd && m_streak < 4'd4) m_streak = m_streak + 4'd1;
    @(posedge CLK);
    #1;
  endtask

  logic [1:0] pat [0:11];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      sram[i]    = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    sram[12'h004] = 32'h00500093;  ref_mem[12'h004] = 32'h00500093;
    sram[12'h010] = 32'h11223344;  ref_mem[12'h010] = 32'h11223344;
    sram[12'h000] = 32'hCAFE0001;  ref_mem[12'h000] = 32'hCAFE0001;
    sram[12'h008] = 32'hBEEF0008;  ref_mem[12'h008] = 32'hBEEF0008;
    sram[12'h020] = 32'h5A5A0020;  ref_mem[12'h020] = 32'h5A5A0020;
    pat = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};

    // Reset with both requests asserted: nothing may be granted.
    RST = 1'b1; I_REQ = 1'b1; I_ADDR = 12'h004;
    D_REQ = 1'b1; D_WEN = 1'b0; D_ADDR = 12'h010; D_BE = 4'hF; D_WDATA = 32'hFFFFFFFF;
    #2;
    chk("rst_grants", {30'd0, D_GNT, I_GNT}, 32'd0);
    chk("rst_mem_ctl", {26'd0, M_CSN, M_WEN, M_BE}, 32'h30);
    chk("rst_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
    chk("rst_rdata", I_RDATA | D_RDATA, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0;
    step();

    // Fetch-only read.
    I_REQ = 1'b1; I_ADDR = 12'h004;
    step();
    I_REQ = 1'b0;
    chk("t1_i_rdata", I_RDATA, 32'h00500093);
    chk("t1_d_rvalid", {31'd0, D_RVALID}, 32'd0);
    step();

    // Partial write then read back.
    D_REQ = 1'b1; D_WEN = 1'b0; D_ADDR = 12'h010; D_BE = 4'b0011; D_WDATA = 32'hAABBCCDD;
    step();
    D_WEN = 1'b1;
    step();
    D_REQ = 1'b0;
    chk("t2_d_rdata", D_RDATA, 32'h1122CCDD);
    step();

    // Contention: fixed grant rhythm D,D,D,D,I.
    I_REQ = 1'b1; I_ADDR = 12'h000; D_REQ = 1'b1; D_WEN = 1'b1; D_ADDR = 12'h008;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t3_pattern", {30'd0, last_gnt}, {30'd0, pat[k]});
    end
    I_REQ = 1'b0; D_REQ = 1'b0;
    step();

    // Back-to-back fetch then data read.
    I_REQ = 1'b1; I_ADDR = 12'h000;
    step();
    I_REQ = 1'b0; D_REQ = 1'b1; D_WEN = 1'b1; D_ADDR = 12'h008;
    chk("t4_i_rdata", I_RDATA, 32'hCAFE0001);
    step();
    D_REQ = 1'b0;
    chk("t4_d_rdata", D_RDATA, 32'hBEEF0008);
    chk("t4_i_quiet", {31'd0, I_RVALID}, 32'd0);
    step();

    // Reset while a data read is in flight, with the streak at its limit.
    I_REQ = 1'b1; I_ADDR = 12'h004; D_REQ = 1'b1; D_WEN = 1'b1; D_ADDR = 12'h008;
    for (int k = 0; k < 4; k++) step();
    RST = 1'b1;
    #1;
    chk("t5_d_rvalid", {31'd0, D_RVALID}, 32'd0);
    chk("t5_m_csn", {31'd0, M_CSN}, 32'd1);
    chk("t5_grants", {30'd0, D_GNT, I_GNT}, 32'd0);
    q.delete();
    m_streak = 4'd0;
    @(posedge CLK); #1;
    chk("t5_rvalid_hold", {30'd0, I_RVALID, D_RVALID}, 32'd0);
    RST = 1'b0; D_REQ = 1'b0;
    step();
    I_REQ = 1'b0;
    chk("t5_i_rdata", I_RDATA, 32'h00500093);
    I_REQ = 1'b1; D_REQ = 1'b1;
    step();
    chk("t5_streak_clear", {30'd0, last_gnt}, 32'd2);

    // Withdrawn data write while fetch is pending.
    for (int k = 0; k < 3; k++) step();
    D_WEN = 1'b0; D_ADDR = 12'h020; D_BE = 4'hF; D_WDATA = 32'h0BADF00D;
    step();
    chk("t6_i_first", {30'd0, last_gnt}, 32'd1);
    D_REQ = 1'b0;
    step();
    I_REQ = 1'b0; D_REQ = 1'b1; D_WEN = 1'b1;
    step();
    D_REQ = 1'b0;
    chk("t6_no_write", D_RDATA, 32'h5A5A0020);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
